// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared widths, micro-op codes and FSM encoding for the MEM stage.
// Defines mem_op codes (NONE, LB, LBU, LH, LHU, LW, SB, SH, SW) and the IDLE/ACCESS state type.
// Helper functions classify stores and detect misaligned halfword/word addresses.
package mem_access_pkg;

    localparam int WORD_WIDTH      = 32;
    localparam int MEM_OP_WIDTH    = 4;
    localparam int REG_ADDR_W      = 5;
    localparam int REG_W_SRC_WIDTH = 2;
    localparam int REG_W_DST_WIDTH = 2;

    localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_NONE = 4'd0;
    localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_LB   = 4'd1;
    localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_LBU  = 4'd2;
    localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_LH   = 4'd3;
    localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_LHU  = 4'd4;
    localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_LW   = 4'd5;
    localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_SB   = 4'd6;
    localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_SH   = 4'd7;
    localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_SW   = 4'd8;

    typedef enum logic {
        MEM_ST_IDLE   = 1'b0,
        MEM_ST_ACCESS = 1'b1
    } mem_state_t;

    function automatic logic is_store(input logic [MEM_OP_WIDTH-1:0] op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

    function automatic logic is_misaligned(input logic [MEM_OP_WIDTH-1:0] op,
                                           input logic [1:0] addr_lo);
        logic half_op;
        logic word_op;
        half_op = (op == MEM_OP_LH) || (op == MEM_OP_LHU) || (op == MEM_OP_SH);
        word_op = (op == MEM_OP_LW) || (op == MEM_OP_SW);
        return (half_op && addr_lo[0]) || (word_op && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// load_extend: selects the addressed byte/halfword lane of a read word and extends it.
// Ports: mem_op, addr (low 2 address bits), rdata (bus word) in; data (extended result) out.
// Purely combinational; stores and NONE produce zero so the MEM/WB load field stays clean.
module load_extend
    import mem_access_pkg::*;
#(
    parameter int W = WORD_WIDTH
) (
    input  logic [MEM_OP_WIDTH-1:0] mem_op,
    input  logic [1:0]              addr,
    input  logic [W-1:0]            rdata,
    output logic [W-1:0]            data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Little-endian lanes: byte k lives at bits 8k+7:8k, halfword uses addr[1] only.
    assign lane_byte = rdata[{addr, 3'b000} +: 8];
    assign lane_half = rdata[{addr[1], 4'b0000} +: 16];

    always_comb begin
        data = '0;
        case (mem_op)
            MEM_OP_LB:  data = {{(W-8){lane_byte[7]}}, lane_byte};
            MEM_OP_LBU: data = {{(W-8){1'b0}}, lane_byte};
            MEM_OP_LH:  data = {{(W-16){lane_half[15]}}, lane_half};
            MEM_OP_LHU: data = {{(W-16){1'b0}}, lane_half};
            MEM_OP_LW:  data = rdata;
            default:    data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: MIPS32 MEM stage; turns load/store micro-ops into one req/ack bus transaction and
// registers MEM/WB results. Ports: EX inputs + in_valid/in_ready/stall, bus_* master, wb_* outputs.
// NONE retires 1 cycle after accept; memory ops hold in_ready low until bus_ack (2 + waits cycles).
// Optional MEM_ALIGN_CHECK_EN adds the misalign output and retires misaligned ops without a bus access.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int W = WORD_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       stall,
    input  logic [MEM_OP_WIDTH-1:0]    mem_op,
    input  logic [W-1:0]               alu_result,
    input  logic [W-1:0]               store_data,
    input  logic [W-1:0]               pc,
    input  logic [REG_ADDR_W-1:0]      rd,
    input  logic [REG_ADDR_W-1:0]      rt,
    input  logic                       reg_write_en,
    input  logic [REG_W_SRC_WIDTH-1:0] reg_write_src,
    input  logic [REG_W_DST_WIDTH-1:0] reg_write_dst,
    output logic                       bus_req,
    output logic                       bus_we,
    output logic [W-1:0]               bus_addr,
    output logic [W/8-1:0]             bus_be,
    output logic [W-1:0]               bus_wdata,
    input  logic [W-1:0]               bus_rdata,
    input  logic                       bus_ack,
    output logic                       wb_valid,
    output logic                       wb_reg_write_en,
    output logic [W-1:0]               wb_alu_result,
    output logic [W-1:0]               wb_mem_data,
    output logic [W-1:0]               wb_pc,
    output logic [REG_ADDR_W-1:0]      wb_rd,
    output logic [REG_ADDR_W-1:0]      wb_rt,
    output logic [REG_W_SRC_WIDTH-1:0] wb_reg_write_src,
    output logic [REG_W_DST_WIDTH-1:0] wb_reg_write_dst
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic                       misalign
`endif
);

    localparam int BE_W = W / 8;

    mem_state_t state, next_state;
    logic       accept;
    logic       direct_retire;
    logic       ack_retire;
    logic       misalign_hit;
    logic       misalign_q;

    logic [MEM_OP_WIDTH-1:0]    lat_op;
    logic [W-1:0]               lat_addr;
    logic [W-1:0]               lat_sd;
    logic [W-1:0]               lat_pc;
    logic [REG_ADDR_W-1:0]      lat_rd;
    logic [REG_ADDR_W-1:0]      lat_rt;
    logic                       lat_rwe;
    logic [REG_W_SRC_WIDTH-1:0] lat_src;
    logic [REG_W_DST_WIDTH-1:0] lat_dst;
    logic [W-1:0]               ld_data;

    always_ff @(posedge clk) begin
        if (rst) state <= MEM_ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state    = state;
        accept        = 1'b0;
        direct_retire = 1'b0;
        ack_retire    = 1'b0;
        misalign_hit  = 1'b0;
        case (state)
            MEM_ST_IDLE: begin
                if (in_valid) begin
                    accept = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
                    misalign_hit = is_misaligned(mem_op, alu_result[1:0]);
`endif
                    // NONE and rejected misaligned ops never touch the bus.
                    if ((mem_op == MEM_OP_NONE) || misalign_hit) direct_retire = 1'b1;
                    else                                         next_state    = MEM_ST_ACCESS;
                end
            end
            MEM_ST_ACCESS: begin
                if (bus_ack) begin
                    ack_retire = 1'b1;
                    next_state = MEM_ST_IDLE;
                end
            end
            default: next_state = MEM_ST_IDLE;
        endcase
    end

    assign in_ready = (state == MEM_ST_IDLE);
    assign stall    = ~in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_op   <= MEM_OP_NONE;
            lat_addr <= '0;
            lat_sd   <= '0;
            lat_pc   <= '0;
            lat_rd   <= '0;
            lat_rt   <= '0;
            lat_rwe  <= 1'b0;
            lat_src  <= '0;
            lat_dst  <= '0;
        end else if (accept) begin
            lat_op   <= mem_op;
            lat_addr <= alu_result;
            lat_sd   <= store_data;
            lat_pc   <= pc;
            lat_rd   <= rd;
            lat_rt   <= rt;
            lat_rwe  <= reg_write_en;
            lat_src  <= reg_write_src;
            lat_dst  <= reg_write_dst;
        end
    end

    // Bus signals come straight from the latched op, so they are stable for the whole request.
    assign bus_req  = (state == MEM_ST_ACCESS);
    assign bus_we   = bus_req && is_store(lat_op);
    assign bus_addr = {lat_addr[W-1:2], 2'b00};

    always_comb begin
        bus_be    = '1;
        bus_wdata = '0;
        case (lat_op)
            MEM_OP_SB: begin
                bus_be    = BE_W'(1) << lat_addr[1:0];
                bus_wdata = {BE_W{lat_sd[7:0]}};
            end
            MEM_OP_SH: begin
                bus_be    = BE_W'(3) << {lat_addr[1], 1'b0};
                bus_wdata = {(W/16){lat_sd[15:0]}};
            end
            MEM_OP_SW: bus_wdata = lat_sd;
            default: ;
        endcase
    end

    load_extend #(.W(W)) u_load_extend (
        .mem_op (lat_op),
        .addr   (lat_addr[1:0]),
        .rdata  (bus_rdata),
        .data   (ld_data)
    );

    // wb_valid and wb_reg_write_en pulse only on retire; other fields hold until the next retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid         <= 1'b0;
            wb_reg_write_en  <= 1'b0;
            wb_alu_result    <= '0;
            wb_mem_data      <= '0;
            wb_pc            <= '0;
            wb_rd            <= '0;
            wb_rt            <= '0;
            wb_reg_write_src <= '0;
            wb_reg_write_dst <= '0;
            misalign_q       <= 1'b0;
        end else begin
            wb_valid        <= 1'b0;
            wb_reg_write_en <= 1'b0;
            misalign_q      <= 1'b0;
            if (direct_retire) begin
                wb_valid         <= 1'b1;
                wb_reg_write_en  <= reg_write_en && !misalign_hit;
                wb_alu_result    <= alu_result;
                wb_mem_data      <= '0;
                wb_pc            <= pc;
                wb_rd            <= rd;
                wb_rt            <= rt;
                wb_reg_write_src <= reg_write_src;
                wb_reg_write_dst <= reg_write_dst;
                misalign_q       <= misalign_hit;
            end else if (ack_retire) begin
                wb_valid         <= 1'b1;
                wb_reg_write_en  <= lat_rwe;
                wb_alu_result    <= lat_addr;
                wb_mem_data      <= ld_data;
                wb_pc            <= lat_pc;
                wb_rd            <= lat_rd;
                wb_rt            <= lat_rt;
                wb_reg_write_src <= lat_src;
                wb_reg_write_dst <= lat_dst;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = misalign_q;
`else
    logic unused_misalign;
    assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: scoreboard bench for mem_access; stimulus pushes expected MEM/WB records,
// a negedge monitor pops and compares them whenever wb_valid is seen.
// Bus responder is driven inline by the stimulus with a programmable number of wait cycles.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready, stall;
    logic [3:0]  mem_op;
    logic [31:0] alu_result, store_data, pc;
    logic [4:0]  rd, rt;
    logic        reg_write_en;
    logic [1:0]  reg_write_src, reg_write_dst;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic        wb_valid, wb_reg_write_en;
    logic [31:0] wb_alu_result, wb_mem_data, wb_pc;
    logic [4:0]  wb_rd, wb_rt;
    logic [1:0]  wb_reg_write_src, wb_reg_write_dst;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign;
`endif

    mem_access dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .stall(stall),
        .mem_op(mem_op), .alu_result(alu_result), .store_data(store_data), .pc(pc),
        .rd(rd), .rt(rt), .reg_write_en(reg_write_en), .reg_write_src(reg_write_src),
        .reg_write_dst(reg_write_dst), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .wb_valid(wb_valid),
        .wb_reg_write_en(wb_reg_write_en), .wb_alu_result(wb_alu_result),
        .wb_mem_data(wb_mem_data), .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_rt(wb_rt),
        .wb_reg_write_src(wb_reg_write_src), .wb_reg_write_dst(wb_reg_write_dst)
`ifdef MEM_ALIGN_CHECK_EN
        , .misalign(misalign)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] alu, mem, pcv;
        logic [4:0]  rdv, rtv;
        logic        rwe, mis;
        logic [1:0]  src, dst;
        int          t0, lat;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: every retired instruction must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wb_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wb_alu_result", wb_alu_result, e.alu);
                check("wb_mem_data", wb_mem_data, e.mem);
                check("wb_pc", wb_pc, e.pcv);
                check("wb_rd", {27'd0, wb_rd}, {27'd0, e.rdv});
                check("wb_rt", {27'd0, wb_rt}, {27'd0, e.rtv});
                check("wb_reg_write_en", {31'd0, wb_reg_write_en}, {31'd0, e.rwe});
                check("wb_reg_write_src", {30'd0, wb_reg_write_src}, {30'd0, e.src});
                check("wb_reg_write_dst", {30'd0, wb_reg_write_dst}, {30'd0, e.dst});
                check("wb_latency", 32'(cyc - e.t0 + 1), 32'(e.lat));
`ifdef MEM_ALIGN_CHECK_EN
                check("misalign", {31'd0, misalign}, {31'd0, e.mis});
`endif
            end
        end
    end

    // Presents one instruction, waits for acceptance, returns #1 after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [31:0] pcv, input logic [4:0] rdv, input logic [4:0] rtv,
                         input logic rwe, input logic [1:0] src, input logic [1:0] dst,
                         input logic [31:0] exp_mem, input logic exp_rwe, input logic exp_mis,
                         input int lat, input bit push);
        int guard = 0;
        exp_t e;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) check("in_ready_timeout", 32'd0, 32'd1);
        mem_op = op; alu_result = alu; store_data = sd; pc = pcv; rd = rdv; rt = rtv;
        reg_write_en = rwe; reg_write_src = src; reg_write_dst = dst;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        e.alu = alu; e.mem = exp_mem; e.pcv = pcv; e.rdv = rdv; e.rtv = rtv;
        e.rwe = exp_rwe; e.mis = exp_mis; e.src = src; e.dst = dst;
        e.t0 = cyc; e.lat = lat;
        if (push) exp_q.push_back(e);
    endtask

    task automatic mem_txn(input string tag, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [31:0] rdata, input int waits,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input logic exp_we, input logic [31:0] exp_mem, input logic rwe);
        issue(op, addr, sd, 32'h1000 + addr, 5'd7, 5'd9, rwe, 2'd2, 2'd1,
              exp_mem, rwe, 1'b0, 2 + waits, 1'b1);
        check({tag, "_bus_req"}, {31'd0, bus_req}, 32'd1);
        check({tag, "_stall"}, {31'd0, stall}, 32'd1);
        check({tag, "_bus_addr"}, bus_addr, {addr[31:2], 2'b00});
        check({tag, "_bus_be"}, {28'd0, bus_be}, {28'd0, exp_be});
        check({tag, "_bus_we"}, {31'd0, bus_we}, {31'd0, exp_we});
        if (exp_we) check({tag, "_bus_wdata"}, bus_wdata, exp_wdata);
        repeat (waits) begin
            @(posedge clk); #1;
            check({tag, "_req_held"}, {31'd0, bus_req}, 32'd1);
        end
        bus_rdata = rdata;
        bus_ack   = 1'b1;
        @(posedge clk); #1;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        check({tag, "_req_drop"}, {31'd0, bus_req}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; mem_op = MEM_OP_NONE; alu_result = '0; store_data = '0;
        pc = '0; rd = '0; rt = '0; reg_write_en = 1'b0; reg_write_src = '0; reg_write_dst = '0;
        bus_rdata = '0; bus_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_bus_req", {31'd0, bus_req}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_alu", wb_alu_result, 32'd0);

        // NONE passes through in one cycle, no bus activity
        issue(MEM_OP_NONE, 32'h1234, 32'h0, 32'h40, 5'd3, 5'd4, 1'b1, 2'd1, 2'd2,
              32'h0, 1'b1, 1'b0, 1, 1'b1);
        check("none_bus_req", {31'd0, bus_req}, 32'd0);

        // Loads: sign/zero extension across lanes and wait states
        mem_txn("lb",  MEM_OP_LB,  32'h103, 32'h0, 32'h80FFFFFF, 2, 4'hF, 32'h0, 1'b0, 32'hFFFFFF80, 1'b1);
        mem_txn("lhu", MEM_OP_LHU, 32'h202, 32'h0, 32'hBEEF0000, 0, 4'hF, 32'h0, 1'b0, 32'h0000BEEF, 1'b1);
        mem_txn("lh",  MEM_OP_LH,  32'h206, 32'h0, 32'h80011234, 0, 4'hF, 32'h0, 1'b0, 32'hFFFF8001, 1'b1);
        mem_txn("lbu", MEM_OP_LBU, 32'h101, 32'h0, 32'h00009A00, 1, 4'hF, 32'h0, 1'b0, 32'h0000009A, 1'b1);
        mem_txn("lw",  MEM_OP_LW,  32'h208, 32'h0, 32'hDEADBEEF, 3, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1);

        // Stores: lane enables and replicated write data
        mem_txn("sb", MEM_OP_SB, 32'h301, 32'h000000A5, 32'h0, 1, 4'b0010, 32'hA5A5A5A5, 1'b1, 32'h0, 1'b0);
        mem_txn("sh", MEM_OP_SH, 32'h302, 32'h1234CAFE, 32'h0, 0, 4'b1100, 32'hCAFECAFE, 1'b1, 32'h0, 1'b0);
        mem_txn("sw", MEM_OP_SW, 32'h30C, 32'h01234567, 32'h0, 0, 4'b1111, 32'h01234567, 1'b1, 32'h0, 1'b0);

        // Back-to-back NONE ops, one per cycle
        issue(MEM_OP_NONE, 32'hAAAA0001, 32'h0, 32'h80, 5'd1, 5'd2, 1'b1, 2'd0, 2'd3,
              32'h0, 1'b1, 1'b0, 1, 1'b1);
        issue(MEM_OP_NONE, 32'hAAAA0002, 32'h0, 32'h84, 5'd5, 5'd6, 1'b0, 2'd3, 2'd0,
              32'h0, 1'b0, 1'b0, 1, 1'b1);

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned word load retires immediately, no bus transaction, no register write
        issue(MEM_OP_LW, 32'h402, 32'h0, 32'h500, 5'd8, 5'd10, 1'b1, 2'd1, 2'd1,
              32'h0, 1'b0, 1'b1, 1, 1'b1);
        check("mis_bus_req", {31'd0, bus_req}, 32'd0);
        check("mis_in_ready", {31'd0, in_ready}, 32'd1);
`else
        // Misaligned halfword store: addr[0] ignored, upper half selected by addr[1]
        mem_txn("sh_odd", MEM_OP_SH, 32'h303, 32'h0000BEEF, 32'h0, 0, 4'b1100, 32'hBEEFBEEF, 1'b1, 32'h0, 1'b0);
`endif

        // Reset in the middle of an access abandons it
        issue(MEM_OP_LW, 32'h20C, 32'h0, 32'h600, 5'd11, 5'd12, 1'b1, 2'd1, 2'd1,
              32'h0, 1'b1, 1'b0, 2, 1'b0);
        check("rstmid_req_before", {31'd0, bus_req}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstmid_bus_req", {31'd0, bus_req}, 32'd0);
        check("rstmid_in_ready", {31'd0, in_ready}, 32'd1);
        check("rstmid_wb_valid", {31'd0, wb_valid}, 32'd0);
        bus_rdata = 32'h55555555;
        bus_ack   = 1'b1;
        @(posedge clk); #1;
        bus_ack   = 1'b0;
        check("late_ack_bus_req", {31'd0, bus_req}, 32'd0);
        check("late_ack_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("late_ack_in_ready", {31'd0, in_ready}, 32'd1);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
